// File: rtl/popcount_enumerator_if.sv
// Request / beat bus of the popcount enumerator.
// master drives requests and consumer ready; slave is the enumerator.
interface popcount_enumerator_if #(
  parameter int W  = 7,
  parameter int CW = $clog2(W+1),
  parameter int IW = 16
);
  logic          req_vld;
  logic [CW-1:0] req_k;
  logic          req_rdy;
  logic          flush;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  out_x;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_err;

  modport master (
    output req_vld, req_k, flush, out_rdy,
    input  req_rdy, out_vld, out_x,
    input  out_idx, out_last, out_err
  );

  modport slave (
    input  req_vld, req_k, flush, out_rdy,
    output req_rdy, out_vld, out_x,
    output out_idx, out_last, out_err
  );
endinterface

// File: rtl/popcount_enumerator.sv
// Emits every W-bit vector of popcount K in ascending order,
// one beat per cycle, using a Gosper next-combination step.
module popcount_enumerator #(
  parameter int W  = 7,
  parameter int CW = $clog2(W+1),
  parameter int IW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  popcount_enumerator_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e        state_q, state_d;
  logic          init_q;
  logic [CW-1:0] k_q, k_d;
  logic [W-1:0]  x_q, x_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic          accept, xfer, k_bad;
  logic [W:0]    xe, ce, re;
  logic [CW-1:0] ctz;
  logic [W-1:0]  nxt;

  function automatic logic [W-1:0] low_mask(
    input logic [CW-1:0] k
  );
    logic [W-1:0] m;
    for (int i = 0; i < W; i++)
      m[i] = (i < int'(k));
    return m;
  endfunction

  function automatic logic [W-1:0] high_mask(
    input logic [CW-1:0] k
  );
    logic [W-1:0] m;
    for (int i = 0; i < W; i++)
      m[i] = (i >= W - int'(k));
    return m;
  endfunction

  assign bus.req_rdy  = init_q && (state_q == IDLE);
  assign bus.out_vld  = (state_q == EMIT);
  assign bus.out_x    = x_q;
  assign bus.out_idx  = idx_q;
  assign bus.out_last = last_q;
  assign bus.out_err  = err_q;

  assign accept = bus.req_rdy && bus.req_vld
               && !bus.flush;
  assign xfer   = bus.out_vld && bus.out_rdy
               && !bus.flush;
  assign k_bad  = int'(bus.req_k) > W;

  // Gosper step in W+1 bits; ctz of the isolated
  // lowest set bit replaces the classic divide.
  always_comb begin
    xe  = {1'b0, x_q};
    ce  = xe & (~xe + (W+1)'(1));
    re  = xe + ce;
    ctz = '0;
    for (int i = W; i >= 0; i--)
      if (ce[i]) ctz = CW'(i);
    nxt = W'((((re ^ xe) >> 2) >> ctz) | re);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    idx_d   = idx_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (1'b1)
      bus.flush: state_d = IDLE;
      accept: begin
        state_d = EMIT;
        k_d     = bus.req_k;
        idx_d   = '0;
        err_d   = k_bad;
        x_d     = k_bad ? '0 : low_mask(bus.req_k);
        last_d  = (bus.req_k == '0)
               || (int'(bus.req_k) >= W);
      end
      xfer && last_q: state_d = IDLE;
      xfer && !last_q: begin
        x_d    = nxt;
        idx_d  = idx_q + IW'(1);
        last_d = (nxt == high_mask(k_q));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      k_q     <= '0;
      x_q     <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      k_q     <= k_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_popcount_enumerator.sv
// Randomised self-checking bench for popcount_enumerator,
// compared against a brute-force ascending enumeration model.
module tb_popcount_enumerator;
  localparam int W  = 7;
  localparam int IW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  popcount_enumerator_if #(.W(7), .IW(16)) b7();
  popcount_enumerator_if #(.W(6), .IW(16)) b6();

  popcount_enumerator #(.W(7), .IW(16)) dut7 (
    .clk(clk), .rst_n(rst_n), .bus(b7.slave)
  );
  popcount_enumerator #(.W(6), .IW(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b6.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] expq[$];
  logic [15:0] got[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    if (k > n) return 0;
    for (int i = 0; i < k; i++)
      r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic build_exp(input int w, input int k);
    expq.delete();
    for (int v = 0; v < (1 << w); v++)
      if ($countones(v) == k) expq.push_back(16'(v));
  endtask

  task automatic start_req(input int k);
    int c = 0;
    while (b7.req_rdy !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    checks++;
    if (b7.req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL req_rdy_wait got=%b want=1",
               b7.req_rdy);
    end
    b7.req_vld = 1'b1;
    b7.req_k   = 3'(k);
    tick();
    b7.req_vld = 1'b0;
  endtask

  task automatic run_stream(input int k, input bit rnd,
                            input string nm);
    int n = 0;
    int cyc = 0;
    int last_i;
    build_exp(W, k);
    last_i = expq.size() - 1;
    got.delete();
    start_req(k);
    checks++;
    if (b7.out_vld !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency out_vld=%b want=1",
               nm, b7.out_vld);
    end
    while (n < expq.size() && cyc < 2000) begin
      b7.out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      checks++;
      if (b7.out_vld !== 1'b1
          || b7.out_x !== expq[n][W-1:0]
          || b7.out_idx !== IW'(n)
          || b7.out_last !== (n == last_i)
          || b7.out_err !== 1'b0) begin
        failures++;
        $display("FAIL %s_beat%0d vld=%b x=%b/%b idx=%0d/%0d last=%b err=%b",
                 nm, n, b7.out_vld, b7.out_x,
                 expq[n][W-1:0], b7.out_idx, n,
                 b7.out_last, b7.out_err);
      end
      checks++;
      if ($countones(b7.out_x) != k) begin
        failures++;
        $display("FAIL %s_pop%0d x=%b want_pop=%0d",
                 nm, n, b7.out_x, k);
      end
      if (b7.out_rdy) begin
        got.push_back(16'(b7.out_x));
        n++;
      end
      tick();
      cyc++;
    end
    b7.out_rdy = 1'b1;
    checks++;
    if (n != binom(W, k)) begin
      failures++;
      $display("FAIL %s_count got=%0d want=%0d",
               nm, n, binom(W, k));
    end
    checks++;
    if (b7.out_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s_end out_vld=%b want=0",
               nm, b7.out_vld);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if (b7.out_vld !== 0 || b7.out_x !== '0
        || b7.out_idx !== '0 || b7.out_last !== 0
        || b7.out_err !== 0 || b7.req_rdy !== 0) begin
      failures++;
      $display("FAIL reset_outs vld=%b x=%b idx=%0d last=%b err=%b rdy=%b want_all_0",
               b7.out_vld, b7.out_x, b7.out_idx,
               b7.out_last, b7.out_err, b7.req_rdy);
    end
    tick();
    tick();
    checks++;
    if (b7.req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_low got=%b want=0",
               b7.req_rdy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (b7.req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy_rise got=%b want=1",
               b7.req_rdy);
    end
  endtask

  task automatic test_k3();
    bit asc = 1'b1;
    run_stream(3, 1'b0, "k3");
    for (int i = 1; i < got.size(); i++)
      if (got[i] <= got[i-1]) asc = 1'b0;
    checks++;
    if (got.size() != 35 || got[0] !== 16'h0007
        || got[1] !== 16'h000B || got[34] !== 16'h0070
        || !asc) begin
      failures++;
      $display("FAIL k3_shape n=%0d asc=%b want n=35 asc=1",
               got.size(), asc);
    end
  endtask

  task automatic test_single();
    run_stream(0, 1'b0, "k0");
    run_stream(7, 1'b0, "k7");
    checks++;
    if (got.size() != 1 || got[0] !== 16'h007F) begin
      failures++;
      $display("FAIL k7_value n=%0d want n=1 x=1111111",
               got.size());
    end
  endtask

  task automatic test_err();
    int c = 0;
    b6.out_rdy = 1'b1;
    while (b6.req_rdy !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    b6.req_vld = 1'b1;
    b6.req_k   = 3'd7;
    tick();
    b6.req_vld = 1'b0;
    checks++;
    if (b6.out_vld !== 1 || b6.out_x !== '0
        || b6.out_err !== 1 || b6.out_last !== 1
        || b6.out_idx !== '0) begin
      failures++;
      $display("FAIL err_beat vld=%b x=%b err=%b last=%b idx=%0d want 1/0/1/1/0",
               b6.out_vld, b6.out_x, b6.out_err,
               b6.out_last, b6.out_idx);
    end
    tick();
    checks++;
    if (b6.out_vld !== 1'b0) begin
      failures++;
      $display("FAIL err_end out_vld=%b want=0",
               b6.out_vld);
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k <= W; k++)
      run_stream(k, 1'b0, $sformatf("sweep%0d", k));
  endtask

  task automatic test_stall();
    run_stream(4, 1'b1, "stall_k4");
  endtask

  task automatic test_back_to_back();
    int c = 0;
    while (b7.req_rdy !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    b7.out_rdy = 1'b1;
    b7.req_k   = 3'd0;
    b7.req_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (b7.out_vld !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL b2b_cyc%0d out_vld=%b want=%b",
                 i, b7.out_vld, (i % 2) == 0);
      end
    end
    b7.req_vld = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    int c = 0;
    b7.out_rdy = 1'b1;
    start_req(3);
    while (b7.out_idx !== IW'(10) && c < 100) begin
      tick();
      c++;
    end
    checks++;
    if (b7.out_idx !== IW'(10)) begin
      failures++;
      $display("FAIL mrst_reach idx=%0d want=10",
               b7.out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (b7.out_vld !== 0 || b7.out_x !== '0
        || b7.out_idx !== '0 || b7.out_last !== 0) begin
      failures++;
      $display("FAIL mrst_zero vld=%b x=%b idx=%0d last=%b want all 0",
               b7.out_vld, b7.out_x, b7.out_idx,
               b7.out_last);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_stream(2, 1'b0, "mrst_k2");
    checks++;
    if (got.size() == 0 || got[0] !== 16'h0003) begin
      failures++;
      $display("FAIL mrst_first n=%0d want first x=0000011",
               got.size());
    end
  endtask

  task automatic test_flush();
    int c = 0;
    b7.out_rdy = 1'b1;
    start_req(3);
    while (b7.out_idx !== IW'(5) && c < 100) begin
      tick();
      c++;
    end
    b7.flush = 1'b1;
    tick();
    b7.flush = 1'b0;
    checks++;
    if (b7.out_vld !== 0 || b7.req_rdy !== 1
        || b7.out_idx !== IW'(5)) begin
      failures++;
      $display("FAIL flush_emit vld=%b rdy=%b idx=%0d want 0/1/5",
               b7.out_vld, b7.req_rdy, b7.out_idx);
    end
    b7.flush   = 1'b1;
    b7.req_vld = 1'b1;
    b7.req_k   = 3'd3;
    tick();
    b7.flush   = 1'b0;
    b7.req_vld = 1'b0;
    checks++;
    if (b7.out_vld !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle out_vld=%b want=0",
               b7.out_vld);
    end
    run_stream(1, 1'b0, "post_flush_k1");
  endtask

  initial begin
    b7.req_vld = 1'b0;
    b7.req_k   = '0;
    b7.flush   = 1'b0;
    b7.out_rdy = 1'b1;
    b6.req_vld = 1'b0;
    b6.req_k   = '0;
    b6.flush   = 1'b0;
    b6.out_rdy = 1'b1;
    test_reset();
    test_k3();
    test_single();
    test_err();
    test_sweep();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
